// File: rtl/sar_search_8_pkg.sv
// rtl/sar_search_8_pkg.sv - shared types and helpers for the SAR search controller
package sar_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    VERIFY,
    DONE
  } sar_state_e;

  typedef struct packed {
    logic equal;
    logic larger;
    logic smaller;
  } cmp_flags_t;

  function automatic logic flags_one_hot(input cmp_flags_t f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search_8_if.sv
// rtl/sar_search_8_if.sv - comparator and control signals of the SAR search controller
interface sar_search_8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_equal;
  logic             cmp_larger;
  logic             cmp_smaller;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, cmp_equal, cmp_larger, cmp_smaller,
    output probe, busy, done, result, found, err
  );

  modport slave (
    output start, cmp_equal, cmp_larger, cmp_smaller,
    input  probe, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search_8_wait_timer.sv
// rtl/sar_search_8_wait_timer.sv - loadable down-counter, expire after CMP_LAT+1 cycles
module sar_wait_timer
  import sar_pkg::*;
#(
  parameter int CMP_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= WAIT_W'(CMP_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - WAIT_W'(1);
    end
  end

  // The cycle the count reaches zero is the last cycle of the wait window.
  assign expire = (cnt == '0);

endmodule

// File: rtl/sar_search_8.sv
// rtl/sar_search_8.sv - successive-approximation search driving comparator B operand
// Optional feature: SAR_SEARCH_EARLY_EXIT_EN ends the search on the first equal trial.
module sar_search_8
  import sar_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  sar_search_8_if.master bus
);

  localparam int               K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [K_W-1:0]   K_TOP = K_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  sar_state_e       state, state_n;
  logic [K_W-1:0]   k, k_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] probe, probe_n;
  logic [WIDTH-1:0] result, result_n;
  logic             found, found_n;
  logic             err, err_n;
  logic             load;
  logic             expire;
  cmp_flags_t       flags;

  assign flags = {bus.cmp_equal, bus.cmp_larger, bus.cmp_smaller};

  sar_wait_timer #(
    .CMP_LAT(CMP_LAT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      acc    <= '0;
      probe  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      acc    <= acc_n;
      probe  <= probe_n;
      result <= result_n;
      found  <= found_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    k_n      = k;
    acc_n    = acc;
    probe_n  = probe;
    result_n = result;
    found_n  = found;
    err_n    = err;
    load     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n   = '0;
          found_n = 1'b0;
          err_n   = 1'b0;
          k_n     = K_TOP;
          probe_n = ONE << K_TOP;
          load    = 1'b1;
          state_n = TRIAL;
        end
      end

      TRIAL: begin
        if (expire) begin
          if (!flags_one_hot(flags)) begin
            err_n    = 1'b1;
            result_n = acc;
            state_n  = DONE;
          end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
          else if (flags.equal) begin
            result_n = probe;
            found_n  = 1'b1;
            state_n  = DONE;
          end
`endif
          else begin
            // Equal keeps the bit, same as larger.
            acc_n[k] = ~flags.smaller;
            load     = 1'b1;
            if (k != '0) begin
              k_n     = k - K_W'(1);
              probe_n = acc_n | (ONE << (k - K_W'(1)));
            end else begin
              probe_n = acc_n;
              state_n = VERIFY;
            end
          end
        end
      end

      VERIFY: begin
        if (expire) begin
          found_n  = flags.equal;
          err_n    = !flags_one_hot(flags);
          result_n = acc;
          state_n  = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.probe  = probe;
  assign bus.busy   = (state == TRIAL) || (state == VERIFY);
  assign bus.done   = (state == DONE);
  assign bus.result = result;
  assign bus.found  = found;
  assign bus.err    = err;

endmodule

// File: tb/tb_sar_search_8.sv
// tb/tb_sar_search_8.sv - self-checking bench with registered comparator model and scoreboard
module tb_sar_search_8;

  localparam int CMP_LAT = 1;

  typedef struct packed {
    logic [7:0]       res;
    logic             found;
    logic             err;
    int               lat;
    int               n;
    logic [8:0][7:0]  seq;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    bit         bad_en;
    logic [7:0] bad_p;
    logic [7:0] exp_res;
    logic       exp_found;
    logic       exp_err;
    bit         extra_start;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_search_8_if #(.WIDTH(8)) bus ();

  sar_search_8 #(
    .WIDTH  (8),
    .CMP_LAT(CMP_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Registered comparator (one cycle of latency) with an optional fault on one probe value.
  logic [7:0] a_val = 8'h00;
  bit         bad_en_r = 1'b0;
  logic [7:0] bad_p_r = 8'h00;
  bit f_eq = 1'b0, f_lg = 1'b0, f_sm = 1'b0;

  always @(posedge clk) begin
    if (bad_en_r && bus.probe == bad_p_r) begin
      f_eq <= 1'b0; f_lg <= 1'b1; f_sm <= 1'b1;
    end else begin
      f_eq <= (a_val == bus.probe);
      f_lg <= (a_val > bus.probe);
      f_sm <= (a_val < bus.probe);
    end
  end

  assign bus.cmp_equal   = f_eq;
  assign bus.cmp_larger  = f_lg;
  assign bus.cmp_smaller = f_sm;

  exp_t sb[$];

  task automatic model(input logic [7:0] a, input bit bad_en, input logic [7:0] bad_p,
                       output exp_t e);
    logic [7:0] acc;
    logic [7:0] p;
    int t;
    e = '0;
    acc = 8'h00;
    p = 8'h80;
    t = 0;
    for (int k = 7; k >= 0; k--) begin
      e.seq[e.n] = p;
      e.n++;
      t++;
      if (bad_en && p == bad_p) begin
        e.lat = t * (CMP_LAT + 1) + 1;
        return;
      end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
      if (p == a) begin
        e.lat = t * (CMP_LAT + 1) + 1;
        return;
      end
`endif
      acc[k] = (a >= p);
      p = (k > 0) ? (acc | (8'h01 << (k - 1))) : acc;
    end
    e.seq[e.n] = p;
    e.n++;
    t++;
    e.lat = t * (CMP_LAT + 1) + 1;
  endtask

  // Monitor: latency, probe per window, probe stability, done pulse shape.
  int         lat_cnt = 0;
  int         bidx = 0;
  int         nrec = 0;
  bit         stable_ok = 1'b1;
  bit         prev_busy = 1'b0;
  bit         prev_done = 1'b0;
  int         done_cnt = 0;
  logic [7:0] rec [0:15];

  always @(negedge clk) begin
    exp_t e;
    bit seq_ok;
    if (bus.busy && !prev_busy) begin
      lat_cnt = 1;
      bidx = 0;
      nrec = 0;
      stable_ok = 1'b1;
    end else if (lat_cnt > 0) begin
      lat_cnt++;
    end
    if (bus.busy && bidx < 32) begin
      if (bidx % 2 == 0) begin
        rec[bidx/2] = bus.probe;
        nrec = bidx / 2 + 1;
      end else if (bus.probe !== rec[bidx/2]) begin
        stable_ok = 1'b0;
      end
      bidx++;
    end
    if (prev_done) chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
    if (bus.done) begin
      done_cnt++;
      chk("busy_low_at_done", {31'b0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {24'b0, bus.result}, {24'b0, e.res});
        chk("found", {31'b0, bus.found}, {31'b0, e.found});
        chk("err", {31'b0, bus.err}, {31'b0, e.err});
        chk("latency", lat_cnt, e.lat);
        seq_ok = (nrec == e.n);
        for (int i = 0; i < 9; i++)
          if (i < e.n && i < nrec && rec[i] !== e.seq[i]) seq_ok = 1'b0;
        chk("probe_sequence", {31'b0, seq_ok}, 32'd1);
        chk("probe_stable", {31'b0, stable_ok}, 32'd1);
      end
      lat_cnt = 0;
    end
    prev_busy = bus.busy;
    prev_done = bus.done;
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    model(v.a, v.bad_en, v.bad_p, e);
    e.res = v.exp_res;
    e.found = v.exp_found;
    e.err = v.exp_err;
    a_val = v.a;
    bad_en_r = v.bad_en;
    bad_p_r = v.bad_p;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("done_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run_search(input vec_t v);
    push_exp(v);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    if (v.extra_start) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
    end
    wait_idle();
  endtask

  vec_t vecs [0:12];

  initial begin
    int d0;
    vec_t v;
    vecs[0]  = '{8'h10, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h5A, 1'b1, 8'h50, 8'h40, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'hC3, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'h01, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h7F, 1'b0, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};
    for (int i = 9; i < 13; i++) begin
      v.a = 8'($urandom_range(0, 255));
      vecs[i] = '{v.a, 1'b0, 8'h00, v.a, 1'b1, 1'b0, 1'b0};
    end

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_probe", {24'b0, bus.probe}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", {24'b0, bus.result}, 32'd0);
    chk("rst_found", {31'b0, bus.found}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_search(vecs[i]);
      if (i == 0) begin
        chk("first_probes", {rec[0], rec[1], rec[2], rec[3]}, 32'h80402010);
      end
    end

    // Reset during a search: aborts with no done pulse.
    push_exp(vecs[7]);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("midrst_probe", {24'b0, bus.probe}, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_result", {24'b0, bus.result}, 32'd0);
    chk("midrst_found", {31'b0, bus.found}, 32'd0);
    chk("midrst_err", {31'b0, bus.err}, 32'd0);
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 32'd0);

    // Start in the DONE cycle is ignored; the following IDLE cycle accepts it.
    push_exp('{8'h33, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0});
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    chk("done_seen", {31'b0, bus.done}, 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    chk("done_cycle_start_ignored", {31'b0, bus.busy}, 32'd0);
    push_exp('{8'h66, 1'b0, 8'h00, 8'h66, 1'b1, 1'b0, 1'b0});
    @(negedge clk) bus.start = 1'b0;
    chk("restart_accepted", {31'b0, bus.busy}, 32'd1);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
